mem_2w_write_scheduler: RTL and testbench

- Write-side front end for the 2-write/4-read LVT register memory.
- Accepts one write request per cycle into an in-order queue and drains up to two entries per cycle onto the memory's two write ports (we0/we1).
- Never drives the same address on both ports in one cycle; same-address pairs are coalesced so the younger write wins.
- Provides a combinational lookup so read-side logic can bypass writes that have not yet reached the memory.

---
 rtl/mem_2w_write_scheduler.sv | 132 +++++++++++++
 tb/tb_mem_2w_write_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_2w_write_scheduler.sv
// In-order write queue feeding the two write ports of the LVT memory, with a youngest-first bypass lookup.
// One cycle from push to port register; in_ready drops only when full, and drain_en gates all issue.
module mem_2w_write_scheduler #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      drain_en,
  output logic                      we0,
  output logic [ADDR_W-1:0]         write_addr_0,
  output logic [DATA_W-1:0]         write_data_0,
  output logic                      we1,
  output logic [ADDR_W-1:0]         write_addr_1,
  output logic [DATA_W-1:0]         write_data_1,
  input  logic [ADDR_W-1:0]         lookup_addr,
  output logic                      lookup_hit,
  output logic [DATA_W-1:0]         lookup_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           queue_q [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_nxt;
  logic             push;
  logic [1:0]       pop_n;
  logic             issue0;
  logic             issue1;
  entry_t           port0_nxt;
  entry_t           port1_nxt;

  assign in_ready = (count < CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push     = in_valid && in_ready;
  assign head_nxt = head + PTR_W'(1);

  // Drain decision looks only at registered state, so a fresh push is never issued on its own edge.
  always_comb begin
    issue0    = 1'b0;
    issue1    = 1'b0;
    pop_n     = 2'd0;
    port0_nxt = queue_q[head];
    port1_nxt = queue_q[head_nxt];
    if (drain_en && (count != '0)) begin
      if (count == CNT_W'(1)) begin
        issue0 = 1'b1;
        pop_n  = 2'd1;
      end else if (queue_q[head].addr == queue_q[head_nxt].addr) begin
        issue0    = 1'b1;
        pop_n     = 2'd2;
        port0_nxt = queue_q[head_nxt];
      end else begin
        issue0 = 1'b1;
        issue1 = 1'b1;
        pop_n  = 2'd2;
      end
    end
  end

  // Entry storage needs no reset; occupancy alone decides which slots are meaningful.
  always_ff @(posedge clock) begin
    if (push) begin
      queue_q[tail] <= entry_t'{addr: in_addr, data: in_data};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      we0          <= 1'b0;
      we1          <= 1'b0;
      write_addr_0 <= '0;
      write_data_0 <= '0;
      write_addr_1 <= '0;
      write_data_1 <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      head  <= head + PTR_W'(pop_n);
      count <= count + CNT_W'(push) - CNT_W'(pop_n);
      we0   <= issue0;
      we1   <= issue1;
      if (issue0) begin
        write_addr_0 <= port0_nxt.addr;
        write_data_0 <= port0_nxt.data;
      end
      if (issue1) begin
        write_addr_1 <= port1_nxt.addr;
        write_data_1 <= port1_nxt.data;
      end
    end
  end

  // Later matches override earlier ones: port 0, port 1, then queue oldest to youngest.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    if (we0 && (write_addr_0 == lookup_addr)) begin
      lookup_hit  = 1'b1;
      lookup_data = write_data_0;
    end
    if (we1 && (write_addr_1 == lookup_addr)) begin
      lookup_hit  = 1'b1;
      lookup_data = write_data_1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (queue_q[head + PTR_W'(i)].addr == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = queue_q[head + PTR_W'(i)].data;
      end
    end
  end

endmodule

// File: tb/tb_mem_2w_write_scheduler.sv
// Directed bench for mem_2w_write_scheduler: reset, single/pair/coalesced issue, full/wrap, bypass lookup.
// Inputs change #1 after the rising edge; outputs are sampled at that same point.
module tb_mem_2w_write_scheduler;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        drain_en;
  logic        we0;
  logic [4:0]  write_addr_0;
  logic [31:0] write_data_0;
  logic        we1;
  logic [4:0]  write_addr_1;
  logic [31:0] write_data_1;
  logic [4:0]  lookup_addr;
  logic        lookup_hit;
  logic [31:0] lookup_data;
  logic [3:0]  count;
  logic        empty;

  int n_chk;
  int n_err;

  mem_2w_write_scheduler #(.ADDR_W(5), .DATA_W(32), .DEPTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .drain_en     (drain_en),
    .we0          (we0),
    .write_addr_0 (write_addr_0),
    .write_data_0 (write_data_0),
    .we1          (we1),
    .write_addr_1 (write_addr_1),
    .write_data_1 (write_data_1),
    .lookup_addr  (lookup_addr),
    .lookup_hit   (lookup_hit),
    .lookup_data  (lookup_data),
    .count        (count),
    .empty        (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "timeout");
  end

  initial begin
    n_chk       = 0;
    n_err       = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_addr     = '0;
    in_data     = '0;
    drain_en    = 1'b0;
    lookup_addr = 5'd0;

    // Reset state
    step();
    step();
    check("rst_we0", we0, 0);
    check("rst_we1", we1, 0);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_empty", empty, 1);
    check("rst_hit", lookup_hit, 0);
    check("rst_addr0", write_addr_0, 0);
    check("rst_data1", write_data_1, 0);
    reset = 1'b0;
    step();

    // Single write: issued one edge after the push edge
    drain_en = 1'b1;
    push(5'd3, 32'hAAAA);
    check("single_count_after_push", count, 1);
    check("single_we0_not_yet", we0, 0);
    lookup_addr = 5'd3;
    step();
    check("single_we0", we0, 1);
    check("single_addr0", write_addr_0, 3);
    check("single_data0", write_data_0, 32'hAAAA);
    check("single_we1", we1, 0);
    check("single_count", count, 0);
    check("single_bypass_port0", lookup_hit, 1);
    check("single_bypass_data", lookup_data, 32'hAAAA);
    step();
    check("single_we0_done", we0, 0);
    check("single_hit_done", lookup_hit, 0);

    // Pair issue
    drain_en = 1'b0;
    push(5'd1, 32'h10);
    push(5'd2, 32'h20);
    check("pair_count2", count, 2);
    drain_en = 1'b1;
    step();
    check("pair_we0", we0, 1);
    check("pair_addr0", write_addr_0, 1);
    check("pair_data0", write_data_0, 32'h10);
    check("pair_we1", we1, 1);
    check("pair_addr1", write_addr_1, 2);
    check("pair_data1", write_data_1, 32'h20);
    check("pair_count0", count, 0);
    drain_en = 1'b0;
    step();
    check("pair_idle_we0", we0, 0);
    check("pair_idle_we1", we1, 0);

    // Coalesce: younger write to the same address wins
    push(5'd5, 32'h11);
    push(5'd5, 32'h22);
    check("coal_count2", count, 2);
    drain_en = 1'b1;
    step();
    check("coal_we0", we0, 1);
    check("coal_addr0", write_addr_0, 5);
    check("coal_data0", write_data_0, 32'h22);
    check("coal_we1", we1, 0);
    check("coal_count0", count, 0);
    drain_en = 1'b0;
    step();

    // Bypass priorities
    push(5'd7, 32'h1);
    push(5'd7, 32'h2);
    lookup_addr = 5'd7;
    #1;
    check("byp_hit7", lookup_hit, 1);
    check("byp_data7", lookup_data, 32'h2);
    lookup_addr = 5'd9;
    #1;
    check("byp_hit9", lookup_hit, 0);
    check("byp_data9", lookup_data, 0);
    lookup_addr = 5'd7;
    drain_en = 1'b1;
    push(5'd7, 32'h3);
    check("byp_port0_data", write_data_0, 32'h2);
    check("byp_port0_we", we0, 1);
    check("byp_count1", count, 1);
    check("byp_queue_over_port", lookup_data, 32'h3);
    drain_en = 1'b0;
    step();
    check("byp_queue_only", lookup_data, 32'h3);
    drain_en = 1'b1;
    step();
    check("byp_port0_hit", lookup_hit, 1);
    check("byp_port0_data3", lookup_data, 32'h3);
    drain_en = 1'b0;
    step();
    check("byp_we_clear_nohit", lookup_hit, 0);

    // Full and wrap, two rounds
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 8; k++) begin
        push(5'(r * 8 + k), 32'h100 * (r + 1) + k);
      end
      check("full_count", count, 8);
      check("full_in_ready", in_ready, 0);
      push(5'd31, 32'hDEAD);
      check("full_ignored_count", count, 8);
      lookup_addr = 5'd31;
      #1;
      check("full_ignored_lookup", lookup_hit, 0);
      drain_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (k == 0 && r == 1) begin
          in_valid = 1'b1;
          in_addr  = 5'd30;
          in_data  = 32'hEE;
        end
        step();
        in_valid = 1'b0;
        check("drain_we0", we0, 1);
        check("drain_addr0", write_addr_0, r * 8 + 2 * k);
        check("drain_data0", write_data_0, 32'h100 * (r + 1) + 2 * k);
        check("drain_we1", we1, 1);
        check("drain_addr1", write_addr_1, r * 8 + 2 * k + 1);
        check("drain_data1", write_data_1, 32'h100 * (r + 1) + 2 * k + 1);
        check("drain_count", count, 6 - 2 * k);
        if (k == 0) check("drain_in_ready_after_pop", in_ready, 1);
      end
      drain_en = 1'b0;
      step();
      check("wrap_empty", empty, 1);
    end

    // Reset mid-drain
    for (int k = 0; k < 4; k++) push(5'(10 + k), 32'h300 + k);
    drain_en = 1'b1;
    step();
    check("mid_we0_before", we0, 1);
    check("mid_count_before", count, 2);
    #2;
    reset = 1'b1;
    #1;
    check("mid_we0", we0, 0);
    check("mid_we1", we1, 0);
    check("mid_count", count, 0);
    check("mid_in_ready", in_ready, 1);
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("post_rst_we0", we0, 0);
      check("post_rst_we1", we1, 0);
      check("post_rst_count", count, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
